// File: rtl/quad_cmd_pkg.sv
// Shared state types, default timing constants and opcodes for the
// QuadCopter command front end and the downstream command/config stage.
package quad_cmd_pkg;

    localparam int unsigned DEF_BAUD_DIV    = 2604;      // 50 MHz / 19200 baud
    localparam int unsigned DEF_TIMEOUT_CYC = 2_000_000;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {B0, B1, B2} pkt_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

    localparam logic [7:0] STPTCH  = 8'h02;
    localparam logic [7:0] STRLL   = 8'h03;
    localparam logic [7:0] STYW    = 8'h04;
    localparam logic [7:0] STTHRST = 8'h05;
    localparam logic [7:0] CAL     = 8'h06;
    localparam logic [7:0] EMER    = 8'h07;
    localparam logic [7:0] MTSOFF  = 8'h08;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: RX synchroniser, byte FSM and baud counter.
// byte_vld / frm_err are single-cycle strobes on the stop-bit sample.
module uart_rx_byte
    import quad_cmd_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       frm_err
);

    localparam logic [11:0] BIT_END  = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_END = 12'(BAUD_DIV / 2 - 1);

    rx_state_t   state, state_nxt;
    logic        rx_meta, rx_sync, rx_prev;
    logic [11:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        fall, half_tick, bit_tick;

    // Synchroniser flops reset to the idle level so reset release is not a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall      = rx_prev & ~rx_sync;
    assign half_tick = (baud_cnt == HALF_END);
    assign bit_tick  = (baud_cnt == BIT_END);
    assign rx_byte   = shift;

    always_comb begin
        state_nxt = state;
        byte_vld  = 1'b0;
        frm_err   = 1'b0;
        unique case (state)
            RX_IDLE:  if (fall) state_nxt = RX_START;
            RX_START: if (half_tick) state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_cnt == 3'd7) state_nxt = RX_STOP;
            RX_STOP: begin
                if (bit_tick) begin
                    state_nxt = RX_IDLE;
                    byte_vld  = rx_sync;
                    frm_err   = ~rx_sync;
                end
            end
            default:  state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            state <= state_nxt;
            if (state == RX_IDLE || (state == RX_START && half_tick) || bit_tick)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 12'd1;
            if (state == RX_START) begin
                bit_cnt <= '0;
            end else if (state == RX_DATA && bit_tick) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift   <= {rx_sync, shift[7:1]};
            end
        end
    end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// UART command front end: assembles 3-byte packets (cmd, data_hi, data_lo)
// with an inter-byte timeout, and serialises single-byte responses on TX.
module uart_cmd_wrapper
    import quad_cmd_pkg::*;
#(
    parameter int unsigned BAUD_DIV    = DEF_BAUD_DIV,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam logic [11:0] BIT_END = 12'(BAUD_DIV - 1);
    localparam logic [20:0] TO_END  = 21'(TIMEOUT_CYC - 1);

    logic [7:0] rx_byte;
    logic       byte_vld, frm_err;

    uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (RX),
        .rx_byte  (rx_byte),
        .byte_vld (byte_vld),
        .frm_err  (frm_err)
    );

    pkt_state_t  pkt_state, pkt_nxt;
    logic [20:0] idle_cnt;
    logic [7:0]  cmd_sh, hi_sh;
    logic        timeout, done;

    assign timeout = (pkt_state != B0) && (idle_cnt == TO_END);
    assign done    = byte_vld && (pkt_state == B2);

    // A byte arriving on the timeout cycle wins: the packet keeps advancing.
    always_comb begin
        pkt_nxt = pkt_state;
        unique case (pkt_state)
            B0: if (byte_vld) pkt_nxt = B1;
            B1: if (byte_vld) pkt_nxt = B2; else if (frm_err || timeout) pkt_nxt = B0;
            B2: if (byte_vld) pkt_nxt = B0; else if (frm_err || timeout) pkt_nxt = B0;
            default: pkt_nxt = B0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_state <= B0;
            idle_cnt  <= '0;
            cmd_sh    <= '0;
            hi_sh     <= '0;
            cmd       <= '0;
            data      <= '0;
            cmd_rdy   <= 1'b0;
        end else begin
            pkt_state <= pkt_nxt;
            if (pkt_state == B0 || byte_vld || timeout)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 21'd1;
            if (byte_vld && pkt_state == B0) cmd_sh <= rx_byte;
            if (byte_vld && pkt_state == B1) hi_sh  <= rx_byte;
            if (done) begin
                cmd  <= cmd_sh;
                data <= {hi_sh, rx_byte};
            end
            if (done)
                cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy || (byte_vld && pkt_state == B0))
                cmd_rdy <= 1'b0;
        end
    end

    tx_state_t   tx_state, tx_nxt;
    logic [9:0]  tx_shift;
    logic [11:0] tx_cnt;
    logic [3:0]  tx_bits;
    logic        tx_tick, tx_last;

    assign tx_tick = (tx_cnt == BIT_END);
    assign tx_last = tx_tick && (tx_bits == 4'd9);
    assign TX      = tx_shift[0];

    always_comb begin
        tx_nxt = tx_state;
        unique case (tx_state)
            TX_IDLE: if (send_resp) tx_nxt = TX_XMIT;
            TX_XMIT: if (tx_last) tx_nxt = TX_IDLE;
            default: tx_nxt = TX_IDLE;
        endcase
    end

    // Shifting in ones leaves the register all-ones, which is the idle line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_shift  <= '1;
            tx_cnt    <= '0;
            tx_bits   <= '0;
            resp_sent <= 1'b0;
        end else begin
            tx_state  <= tx_nxt;
            resp_sent <= (tx_state == TX_XMIT) && tx_last;
            if (tx_state == TX_IDLE) begin
                tx_cnt  <= '0;
                tx_bits <= '0;
                if (send_resp) tx_shift <= {1'b1, resp, 1'b0};
            end else if (tx_tick) begin
                tx_cnt   <= '0;
                tx_bits  <= tx_bits + 4'd1;
                tx_shift <= {1'b1, tx_shift[9:1]};
            end else begin
                tx_cnt <= tx_cnt + 12'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper: packet table, TX frame checks,
// corner-case sequences and randomized byte streams against a packet model.
module tb_uart_cmd_wrapper;

    localparam int unsigned BD = 16;
    localparam int unsigned TO = 400;

    logic        clk = 1'b0;
    logic        rst, rx, tx, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent;
    logic [7:0]  cmd, resp;
    logic [15:0] data;

    int unsigned n_cmp  = 0;
    int unsigned n_bad  = 0;
    int unsigned n_done = 0;
    logic        rdy_prev = 1'b0;

    always #5 clk = ~clk;

    uart_cmd_wrapper #(.BAUD_DIV(BD), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (rx),
        .TX          (tx),
        .cmd         (cmd),
        .data        (data),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent)
    );

    // Every delivered packet shows up as a rising edge of cmd_rdy.
    always @(negedge clk) begin
        if (cmd_rdy && !rdy_prev) n_done++;
        rdy_prev = cmd_rdy;
    end

    typedef struct {
        int unsigned kind;      // 0 plain, 1 stale partial then timeout, 2 framing error mid-packet
        logic [7:0]  b0, b1, b2;
        logic [7:0]  exp_cmd;
        logic [15:0] exp_data;
    } pkt_vec_t;

    pkt_vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (BD) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic tx_frame_check(input logic [7:0] b);
        logic [9:0]  got;
        int unsigned seen;
        got  = '0;
        seen = 0;
        resp = b;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        for (int unsigned t = 0; t < 10 * BD + 4; t++) begin
            if (t % BD == BD / 2 && t / BD < 10) got[t / BD] = tx;
            if (resp_sent) seen++;
            @(negedge clk);
        end
        check("tx_rand_frame", {22'd0, got}, {22'd0, 1'b1, b, 1'b0});
        check("tx_rand_sent", seen, 1);
    endtask

    initial begin
        logic [9:0]  frame;
        logic [7:0]  q[$];
        logic [7:0]  m_cmd, rb;
        logic [15:0] m_data;
        int unsigned done0, m_done, wave_err, sent_cnt, sent_t, kind;
        logic        seen;

        vecs[0] = '{0, 8'h02, 8'hBE, 8'hEF, 8'h02, 16'hBEEF};
        vecs[1] = '{1, 8'h06, 8'h00, 8'h00, 8'h06, 16'h0000};
        vecs[2] = '{2, 8'h04, 8'h8D, 8'hA0, 8'h04, 16'h8DA0};
        vecs[3] = '{0, 8'h05, 8'h00, 8'h45, 8'h05, 16'h0045};

        rst = 1'b1; rx = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx", {31'd0, tx}, 1);
        check("rst_cmd", {24'd0, cmd}, 0);
        check("rst_data", {16'd0, data}, 0);
        check("rst_cmd_rdy", {31'd0, cmd_rdy}, 0);
        check("rst_resp_sent", {31'd0, resp_sent}, 0);

        // Packet table: plain packets, timeout of a partial, framing error mid-packet.
        for (int i = 0; i < 4; i++) begin
            done0 = n_done;
            if (vecs[i].kind == 1) begin
                send_byte(8'h03, 1'b1);
                send_byte(8'h1F, 1'b1);
                repeat (TO + 10) @(negedge clk);
            end else if (vecs[i].kind == 2) begin
                send_byte(8'h11, 1'b1);
                send_byte(8'h22, 1'b0);
                repeat (BD) @(negedge clk);
            end
            send_byte(vecs[i].b0, 1'b1);
            send_byte(vecs[i].b1, 1'b1);
            send_byte(vecs[i].b2, 1'b1);
            repeat (4) @(negedge clk);
            check("pkt_cmd", {24'd0, cmd}, {24'd0, vecs[i].exp_cmd});
            check("pkt_data", {16'd0, data}, {16'd0, vecs[i].exp_data});
            check("pkt_rdy", {31'd0, cmd_rdy}, 1);
            check("pkt_count", n_done - done0, 1);
            if (i == 0) begin
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                check("clr_rdy", {31'd0, cmd_rdy}, 0);
                check("clr_cmd_hold", {24'd0, cmd}, 32'h02);
                check("clr_data_hold", {16'd0, data}, 32'hBEEF);
            end
        end

        // TX frame 0xA5 with an ignored second request mid-frame.
        frame = {1'b1, 8'hA5, 1'b0};
        wave_err = 0; sent_cnt = 0; sent_t = 0;
        resp = 8'hA5;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        for (int unsigned t = 0; t < 10 * BD + 4; t++) begin
            if (tx !== ((t < 10 * BD) ? frame[t / BD] : 1'b1)) wave_err++;
            if (t % BD == BD / 2 && t / BD < 10)
                check("tx_bit", {31'd0, tx}, {31'd0, frame[t / BD]});
            if (resp_sent) begin sent_cnt++; sent_t = t; end
            if (t == 3 * BD) begin resp = 8'h5A; send_resp = 1'b1; end
            else send_resp = 1'b0;
            @(negedge clk);
        end
        check("tx_wave_errs", wave_err, 0);
        check("tx_sent_count", sent_cnt, 1);
        check("tx_sent_time", {31'd0, (sent_t + 1 >= 10 * BD) && (sent_t <= 10 * BD + 1)}, 1);
        repeat (2 * BD) @(negedge clk);
        for (int k = 0; k < 3; k++) tx_frame_check(8'($urandom));

        // clr_cmd_rdy held through the completing cycle: set must win.
        send_byte(8'h07, 1'b1);
        send_byte(8'h12, 1'b1);
        clr_cmd_rdy = 1'b1;
        seen = 1'b0;
        fork
            send_byte(8'h34, 1'b1);
            begin
                for (int unsigned k = 0; k < 11 * BD; k++) begin
                    @(negedge clk);
                    if (cmd_rdy) begin
                        seen = 1'b1;
                        clr_cmd_rdy = 1'b0;
                        break;
                    end
                end
                clr_cmd_rdy = 1'b0;
            end
        join
        check("setwins_seen", {31'd0, seen}, 1);
        check("setwins_rdy", {31'd0, cmd_rdy}, 1);
        check("setwins_data", {8'd0, cmd, data}, 32'h071234);

        // One-cycle low glitch on idle RX: no byte, so cmd_rdy is not knocked down.
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (3 * BD) @(negedge clk);
        check("glitch_rdy", {31'd0, cmd_rdy}, 1);

        // Randomized byte stream against a packet-assembly model.
        m_cmd = 8'h07; m_data = 16'h1234; m_done = 0;
        done0 = n_done;
        for (int ev = 0; ev < 14; ev++) begin
            kind = $urandom_range(0, 11);
            rb = 8'($urandom);
            if (kind <= 8) begin
                send_byte(rb, 1'b1);
                q.push_back(rb);
                if (q.size() == 3) begin
                    m_cmd  = q[0];
                    m_data = {q[1], q[2]};
                    m_done++;
                    q.delete();
                end
            end else if (kind == 9) begin
                send_byte(rb, 1'b0);
                q.delete();
                repeat (BD) @(negedge clk);
            end else begin
                repeat (TO + 10) @(negedge clk);
                q.delete();
            end
            repeat ($urandom_range(1, 20)) @(negedge clk);
            check("rand_cmd", {24'd0, cmd}, {24'd0, m_cmd});
            check("rand_data", {16'd0, data}, {16'd0, m_data});
            check("rand_count", n_done - done0, m_done);
        end

        // Reset mid-byte-2 while a TX frame of 0x00 is on the line.
        repeat (TO + 10) @(negedge clk);
        send_byte(8'h09, 1'b1);
        resp = 8'h00;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        rx = 1'b0;
        repeat (3 * BD) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_tx", {31'd0, tx}, 1);
        check("rst_mid_rdy", {31'd0, cmd_rdy}, 0);
        check("rst_mid_cmd", {24'd0, cmd}, 0);
        check("rst_mid_data", {16'd0, data}, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h45, 1'b1);
        repeat (4) @(negedge clk);
        check("post_rst_pkt", {8'd0, cmd, data}, 32'h050045);
        check("post_rst_rdy", {31'd0, cmd_rdy}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
